// File: rtl/ex_stage.sv
// ex_stage -- execute stage of a 5-stage RISC-V style pipeline.
//
// Forwards operands from EX/MEM and MEM/WB, evaluates the ALU and registers
// the EX/MEM pipeline outputs.
//
// Optional feature macro: EX_MUL_ITER_EN
//   defined   : mul runs on a 32-step shift-add FSM (IDLE/BUSY/DONE) and
//               raises stall_o while it works.
//   undefined : mul is single-cycle like every other op; stall_o is tied to 0.
//
// Ports
//   clk_i, start_i                   clock, async active-low reset
//   instr_i[9:0]                     {funct7, funct3}
//   RegWrite_i .. ALUSrc_i, ALUOp_i  ID/EX control
//   imm_i, RS1data_i, RS2data_i      immediate and register operands
//   RS1addr_i, RS2addr_i, RDaddr_i   register addresses
//   MEM_* / WB_*                     forwarding sources
//   RegWrite_o .. MemWrite_o         registered EX/MEM control
//   ALUResult_o, MemWdata_o, RDaddr_o registered EX/MEM data
//   stall_o                          combinational hold request upstream
module ex_stage (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic [9:0]  instr_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        ALUSrc_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] RS1data_i,
  input  logic [31:0] RS2data_i,
  input  logic [4:0]  RS1addr_i,
  input  logic [4:0]  RS2addr_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        MEM_RegWrite_i,
  input  logic [4:0]  MEM_RDaddr_i,
  input  logic [31:0] MEM_data_i,
  input  logic        WB_RegWrite_i,
  input  logic [4:0]  WB_RDaddr_i,
  input  logic [31:0] WB_data_i,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] MemWdata_o,
  output logic [4:0]  RDaddr_o,
  output logic        stall_o
);

  logic [31:0] fwd_a_s;
  logic [31:0] fwd_b_s;
  logic [31:0] op_b_s;
  logic [31:0] alu_res_s;

  // Operand forwarding: the younger EX/MEM result wins over MEM/WB; x0 never forwards.
  always_comb begin
    fwd_a_s = RS1data_i;
    fwd_b_s = RS2data_i;
    if (MEM_RegWrite_i && (MEM_RDaddr_i != 5'd0) && (MEM_RDaddr_i == RS1addr_i)) begin
      fwd_a_s = MEM_data_i;
    end else if (WB_RegWrite_i && (WB_RDaddr_i != 5'd0) && (WB_RDaddr_i == RS1addr_i)) begin
      fwd_a_s = WB_data_i;
    end else begin
      fwd_a_s = RS1data_i;
    end
    if (MEM_RegWrite_i && (MEM_RDaddr_i != 5'd0) && (MEM_RDaddr_i == RS2addr_i)) begin
      fwd_b_s = MEM_data_i;
    end else if (WB_RegWrite_i && (WB_RDaddr_i != 5'd0) && (WB_RDaddr_i == RS2addr_i)) begin
      fwd_b_s = WB_data_i;
    end else begin
      fwd_b_s = RS2data_i;
    end
    op_b_s = ALUSrc_i ? imm_i : fwd_b_s;
  end

  // ALU decode; unlisted encodings produce zero.
  always_comb begin
    alu_res_s = 32'd0;
    case (ALUOp_i)
      2'b00: alu_res_s = fwd_a_s + op_b_s;
      2'b01: alu_res_s = fwd_a_s - op_b_s;
      2'b10: begin
        case (instr_i)
          10'b0000000_111: alu_res_s = fwd_a_s & op_b_s;
          10'b0000000_100: alu_res_s = fwd_a_s ^ op_b_s;
          10'b0000000_001: alu_res_s = fwd_a_s << op_b_s[4:0];
          10'b0000000_000: alu_res_s = fwd_a_s + op_b_s;
          10'b0100000_000: alu_res_s = fwd_a_s - op_b_s;
`ifdef EX_MUL_ITER_EN
          // Result comes from the iterative multiplier instead.
          10'b0000001_000: alu_res_s = 32'd0;
`else
          10'b0000001_000: alu_res_s = fwd_a_s * op_b_s;
`endif
          default:         alu_res_s = 32'd0;
        endcase
      end
      2'b11: begin
        case (instr_i[2:0])
          3'b000:  alu_res_s = fwd_a_s + op_b_s;
          3'b101:  alu_res_s = $signed(fwd_a_s) >>> imm_i[4:0];
          default: alu_res_s = 32'd0;
        endcase
      end
      default: alu_res_s = 32'd0;
    endcase
  end

`ifdef EX_MUL_ITER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic        is_mul_s;
  logic        stall_s;
  logic [31:0] mul_a_r;
  logic [31:0] mul_b_r;
  logic [31:0] acc_r;
  logic [4:0]  count_r;
  logic [3:0]  hold_ctrl_r;
  logic [4:0]  hold_rd_r;
  logic [31:0] hold_wd_r;

  assign is_mul_s = (ALUOp_i == 2'b10) && (instr_i == 10'b0000001_000);
  // Reset must drop the stall immediately, independent of the clock.
  assign stall_o  = start_i & stall_s;

  // Multiplier state register.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Multiplier next state and stall; DONE always returns to IDLE so the same mul cannot retrigger.
  always_comb begin
    state_nx_s = state_r;
    stall_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_mul_s) begin
          stall_s    = 1'b1;
          state_nx_s = BUSY;
        end else begin
          stall_s    = 1'b0;
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        if (count_r == 5'd31) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = BUSY;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Shift-add datapath; operands are captured once so later forwarding changes cannot disturb them.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      mul_a_r     <= 32'd0;
      mul_b_r     <= 32'd0;
      acc_r       <= 32'd0;
      count_r     <= 5'd0;
      hold_ctrl_r <= 4'd0;
      hold_rd_r   <= 5'd0;
      hold_wd_r   <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (is_mul_s) begin
            mul_a_r     <= fwd_a_s;
            mul_b_r     <= op_b_s;
            acc_r       <= 32'd0;
            count_r     <= 5'd0;
            hold_ctrl_r <= {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i};
            hold_rd_r   <= RDaddr_i;
            hold_wd_r   <= fwd_b_s;
          end
        end
        BUSY: begin
          acc_r   <= acc_r + (mul_b_r[0] ? mul_a_r : 32'd0);
          mul_a_r <= mul_a_r << 1;
          mul_b_r <= mul_b_r >> 1;
          count_r <= count_r + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end
`else
  assign stall_o = 1'b0;
`endif

  // EX/MEM pipeline register: bubble while stalled, multiplier result in DONE, ALU result otherwise.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o} <= 4'd0;
      ALUResult_o <= 32'd0;
      MemWdata_o  <= 32'd0;
      RDaddr_o    <= 5'd0;
`ifdef EX_MUL_ITER_EN
    end else if (stall_s) begin
      {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o} <= 4'd0;
      ALUResult_o <= 32'd0;
      MemWdata_o  <= 32'd0;
      RDaddr_o    <= 5'd0;
    end else if (state_r == DONE) begin
      {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o} <= hold_ctrl_r;
      ALUResult_o <= acc_r;
      MemWdata_o  <= hold_wd_r;
      RDaddr_o    <= hold_rd_r;
`endif
    end else begin
      {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o} <= {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i};
      ALUResult_o <= alu_res_s;
      MemWdata_o  <= fwd_b_s;
      RDaddr_o    <= RDaddr_i;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes hand-computed EX/MEM
// contents, a negedge monitor pops and compares whenever a valid
// (non-bubble) instruction appears at the outputs.
module tb_ex_stage;

  logic        clk_i = 1'b0;
  logic        start_i = 1'b0;
  logic [9:0]  instr_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] imm_i, RS1data_i, RS2data_i;
  logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;
  logic        MEM_RegWrite_i, WB_RegWrite_i;
  logic [4:0]  MEM_RDaddr_i, WB_RDaddr_i;
  logic [31:0] MEM_data_i, WB_data_i;
  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
  logic [31:0] ALUResult_o, MemWdata_o;
  logic [4:0]  RDaddr_o;
  logic        stall_o;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk_i(clk_i), .start_i(start_i), .instr_i(instr_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
    .imm_i(imm_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .MEM_RegWrite_i(MEM_RegWrite_i), .MEM_RDaddr_i(MEM_RDaddr_i), .MEM_data_i(MEM_data_i),
    .WB_RegWrite_i(WB_RegWrite_i), .WB_RDaddr_i(WB_RDaddr_i), .WB_data_i(WB_data_i),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ALUResult_o(ALUResult_o), .MemWdata_o(MemWdata_o),
    .RDaddr_o(RDaddr_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task clear_in();
    instr_i = 10'd0; {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i} = 5'd0;
    ALUOp_i = 2'b00; imm_i = 32'd0; RS1data_i = 32'd0; RS2data_i = 32'd0;
    RS1addr_i = 5'd0; RS2addr_i = 5'd0; RDaddr_i = 5'd0;
    MEM_RegWrite_i = 1'b0; MEM_RDaddr_i = 5'd0; MEM_data_i = 32'd0;
    WB_RegWrite_i = 1'b0; WB_RDaddr_i = 5'd0; WB_data_i = 32'd0;
  endtask

  // Push the expected EX/MEM content for the currently driven instruction, then clock it in.
  task go(input logic [31:0] er, input logic [31:0] ew);
    q.push_back({{RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i}, er, ew, RDaddr_i});
    @(posedge clk_i); #1;
  endtask

  task run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er);
    int n;
    bit bub_err;
    clear_in();
    ALUOp_i = 2'b10; instr_i = 10'b0000001_000; RS1addr_i = 5'd1; RS2addr_i = 5'd2;
    RS1data_i = a; RS2data_i = b; RDaddr_i = 5'd9; RegWrite_i = 1'b1;
    q.push_back({4'b1000, er, b, 5'd9});
`ifdef EX_MUL_ITER_EN
    #1;
    n = 0; bub_err = 1'b0;
    while (stall_o && n < 100) begin
      n++;
      // Disturb forwarding mid-multiply; latched operands must not notice.
      if (n == 5) begin
        MEM_RegWrite_i = 1'b1; MEM_RDaddr_i = 5'd1; MEM_data_i = 32'hDEAD_BEEF;
      end
      @(posedge clk_i); #1;
      if (stall_o && ({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o} != 4'd0 ||
                      ALUResult_o != 32'd0 || MemWdata_o != 32'd0 || RDaddr_o != 5'd0))
        bub_err = 1'b1;
    end
    chk("mul_stall_cycles", n, 32'd33);
    chk("mul_bubbles", {31'd0, bub_err}, 32'd0);
    @(posedge clk_i); #1;
`else
    #1;
    chk("mul_no_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
`endif
  endtask

  // Monitor: every valid instruction leaving EX must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (start_i && (RegWrite_o | MemtoReg_o | MemRead_o | MemWrite_o)) begin
      exp_t e;
      exp_t got;
      checks++;
      got = {{RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}, ALUResult_o, MemWdata_o, RDaddr_o};
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", got);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL exmem actual=%h required=%h", got, e);
        end
      end
    end
  end

  initial begin
    clear_in();
    // Reset with a mul presented: everything stays zero, no stall.
    ALUOp_i = 2'b10; instr_i = 10'b0000001_000; RegWrite_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_stall", {31'd0, stall_o}, 32'd0);
    chk("reset_outputs", {23'd0, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, RDaddr_o} |
        ALUResult_o | MemWdata_o, 32'd0);
    clear_in();
    start_i = 1'b1;
    @(posedge clk_i); #1;

    // add 5+7
    RS1data_i = 32'd5; RS2data_i = 32'd7; RS1addr_i = 5'd1; RS2addr_i = 5'd2;
    RDaddr_i = 5'd3; RegWrite_i = 1'b1;
    go(32'd12, 32'd7);
    // sub with MEM and WB both matching RS1: MEM wins
    clear_in();
    ALUOp_i = 2'b01; RS1addr_i = 5'd4; RS1data_i = 32'd1; RS2addr_i = 5'd6; RS2data_i = 32'd30;
    MEM_RegWrite_i = 1'b1; MEM_RDaddr_i = 5'd4; MEM_data_i = 32'd100;
    WB_RegWrite_i = 1'b1; WB_RDaddr_i = 5'd4; WB_data_i = 32'd50;
    RDaddr_i = 5'd5; RegWrite_i = 1'b1; MemtoReg_i = 1'b1;
    go(32'd70, 32'd30);
    MEM_RDaddr_i = 5'd0;                       // x0 never forwards: WB supplies A
    go(32'd20, 32'd30);
    // srai
    clear_in();
    ALUOp_i = 2'b11; instr_i = 10'b0100000_101; ALUSrc_i = 1'b1; imm_i = 32'd4;
    RS1data_i = 32'h8000_0010; RDaddr_i = 5'd7; RegWrite_i = 1'b1;
    go(32'hF800_0001, 32'd0);
    // R-type group
    clear_in();
    ALUOp_i = 2'b10; instr_i = 10'b0000000_001; RS1data_i = 32'd3; RS2data_i = 32'd33;
    RDaddr_i = 5'd8; RegWrite_i = 1'b1;
    go(32'd6, 32'd33);                         // sll uses B[4:0]=1
    instr_i = 10'b0000000_111; RS1data_i = 32'hF0F0_F0F0; RS2data_i = 32'hFF00_FF00;
    go(32'hF000_F000, 32'hFF00_FF00);
    instr_i = 10'b0000000_100;
    go(32'h0FF0_0FF0, 32'hFF00_FF00);
    instr_i = 10'b0000000_000; RS1data_i = 32'hFFFF_FFFF; RS2data_i = 32'd2;
    go(32'd1, 32'd2);                          // wraps
    instr_i = 10'b0100000_000; RS1data_i = 32'd5; RS2data_i = 32'd7;
    go(32'hFFFF_FFFE, 32'd7);
    instr_i = 10'b0100000_111;
    go(32'd0, 32'd7);                          // undefined encoding
    // I-type group
    clear_in();
    ALUOp_i = 2'b11; instr_i = 10'b0000000_000; ALUSrc_i = 1'b1; imm_i = 32'hFFFF_FFFF;
    RS1data_i = 32'd10; RS2data_i = 32'h55; RDaddr_i = 5'd10; RegWrite_i = 1'b1; MemRead_i = 1'b1;
    go(32'd9, 32'h55);
    instr_i = 10'b0000000_001;
    go(32'd0, 32'h55);
    // Forward B from WB, then WB disabled, then MEM on B with immediate operand
    clear_in();
    RS1addr_i = 5'd3; RS1data_i = 32'd1; RS2addr_i = 5'd7; RS2data_i = 32'd99;
    WB_RegWrite_i = 1'b1; WB_RDaddr_i = 5'd7; WB_data_i = 32'h1234;
    MEM_RegWrite_i = 1'b1; MEM_RDaddr_i = 5'd8; MEM_data_i = 32'hBAD; MemWrite_i = 1'b1;
    go(32'h1235, 32'h1234);
    WB_RegWrite_i = 1'b0;
    go(32'd100, 32'd99);
    MEM_RDaddr_i = 5'd7; ALUSrc_i = 1'b1; imm_i = 32'h10;
    go(32'h11, 32'hBAD);
    // Multiply, then a back-to-back second multiply
    run_mul(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    run_mul(32'd7, 32'd6, 32'd42);

    // Reset while a result sits on the outputs clears them at once
    clear_in();
    RS1data_i = 32'd5; RS2data_i = 32'd7; RDaddr_i = 5'd3; RegWrite_i = 1'b1;
    go(32'd12, 32'd7);
    #6;
    start_i = 1'b0;
    #1;
    chk("async_reset_outputs", {27'd0, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, stall_o} |
        ALUResult_o | MemWdata_o, 32'd0);
    clear_in();
    @(posedge clk_i); #1;
    start_i = 1'b1;
`ifdef EX_MUL_ITER_EN
    // Abort a mul at BUSY count=10
    ALUOp_i = 2'b10; instr_i = 10'b0000001_000; RS1data_i = 32'd3; RS2data_i = 32'd3;
    RegWrite_i = 1'b1; RDaddr_i = 5'd4;
    repeat (11) @(posedge clk_i);
    #1;
    chk("busy_stall", {31'd0, stall_o}, 32'd1);
    start_i = 1'b0;
    #1;
    chk("abort_outputs", {27'd0, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, stall_o} |
        ALUResult_o | MemWdata_o, 32'd0);
    clear_in();
    @(posedge clk_i); #1;
    start_i = 1'b1;
`endif
    RS1data_i = 32'd20; RS2data_i = 32'd22; RDaddr_i = 5'd11; RegWrite_i = 1'b1;
    go(32'd42, 32'd22);
    clear_in();
    repeat (3) @(posedge clk_i);
    #1;
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
